// File: rtl/l2_arbiter.sv
// l2_arbiter: two-port (I-cache read-only, D-cache read/write) arbiter in
// front of a single L2 port. Ties go to the port not served last. The
// request is forwarded combinationally from the granted port. A sticky
// watchdog flags grants that stay open too long.
module l2_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  // I-cache port (read-only)
  input  logic              i_action_stb,
  input  logic              i_action_cyc,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_resp,
  output logic              i_retry,
  output logic [LINE_W-1:0] i_rdata,
  // D-cache port
  input  logic              d_action_stb,
  input  logic              d_action_cyc,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic              d_retry,
  output logic [LINE_W-1:0] d_rdata,
  // L2 side
  output logic              l2_action_stb,
  output logic              l2_action_cyc,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic              l2_resp,
  input  logic              l2_retry,
  input  logic [LINE_W-1:0] l2_rdata,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  logic [1:0]       state, state_nxt;
  logic             last_d;     // 1: D was served last, 0: I (reset value)
  logic [CNT_W-1:0] wd_cnt;
  logic             i_req, d_req, in_gnt;

  // l2_retry is a pure wait hint; completion is signalled only by l2_resp
  logic unused_l2_retry;
  assign unused_l2_retry = l2_retry;

  assign i_req  = i_action_stb & i_action_cyc;
  assign d_req  = d_action_stb & d_action_cyc;
  assign in_gnt = (state == GNT_I) | (state == GNT_D);

  // Next-state: round-robin pick in IDLE, leave a grant on resp or abort
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_req && d_req) state_nxt = last_d ? GNT_I : GNT_D;
        else if (i_req)     state_nxt = GNT_I;
        else if (d_req)     state_nxt = GNT_D;
      end
      GNT_I:   if (l2_resp || !i_action_cyc) state_nxt = IDLE;
      GNT_D:   if (l2_resp || !d_action_cyc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and last-served record; priority moves only on a completed transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      state <= state_nxt;
      if (in_gnt && l2_resp) last_d <= (state == GNT_D);
    end
  end

  // Watchdog: restart on each new grant, count grant cycles, saturate, sticky flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else if (state == IDLE && state_nxt != IDLE) begin
      wd_cnt <= '0;
    end else if (in_gnt && wd_cnt != TO_VAL) begin
      wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt + 1'b1 == TO_VAL) timeout_err <= 1'b1;
    end
  end

  // Forward the granted port to L2 and route l2_resp back to it
  always_comb begin
    l2_action_stb = 1'b0;
    l2_action_cyc = 1'b0;
    l2_write      = 1'b0;
    l2_address    = '0;
    l2_wdata      = '0;
    i_resp        = 1'b0;
    d_resp        = 1'b0;
    case (state)
      GNT_I: begin
        l2_action_stb = i_action_stb;
        l2_action_cyc = i_action_cyc;
        l2_address    = i_address;
        i_resp        = l2_resp;
      end
      GNT_D: begin
        l2_action_stb = d_action_stb;
        l2_action_cyc = d_action_cyc;
        l2_write      = d_write;
        l2_address    = d_address;
        l2_wdata      = d_wdata;
        d_resp        = l2_resp;
      end
      default: ;
    endcase
  end

  assign i_retry = i_req & ~i_resp;
  assign d_retry = d_req & ~d_resp;
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: table-driven directed sequence, hand-written corner cases
// and randomized traffic, all checked against a transaction-level model.
module tb_l2_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic i_action_stb, i_action_cyc;
  logic [AW-1:0] i_address;
  logic i_resp, i_retry;
  logic [LW-1:0] i_rdata;
  logic d_action_stb, d_action_cyc, d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic d_resp, d_retry;
  logic [LW-1:0] d_rdata;
  logic l2_action_stb, l2_action_cyc, l2_write;
  logic [AW-1:0] l2_address;
  logic [LW-1:0] l2_wdata;
  logic l2_resp, l2_retry;
  logic [LW-1:0] l2_rdata;
  logic timeout_err;

  always #5 clk = ~clk;

  l2_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_action_stb(i_action_stb), .i_action_cyc(i_action_cyc), .i_address(i_address),
    .i_resp(i_resp), .i_retry(i_retry), .i_rdata(i_rdata),
    .d_action_stb(d_action_stb), .d_action_cyc(d_action_cyc), .d_write(d_write),
    .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_retry(d_retry), .d_rdata(d_rdata),
    .l2_action_stb(l2_action_stb), .l2_action_cyc(l2_action_cyc), .l2_write(l2_write),
    .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_resp(l2_resp), .l2_retry(l2_retry), .l2_rdata(l2_rdata),
    .timeout_err(timeout_err)
  );

  int ntests = 0;
  int nfail  = 0;

  function automatic void chk(string nm, logic [LW-1:0] act, logic [LW-1:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Reference model: who owns the L2 port (0 none, 1 I, 2 D), who was
  // served last, how many cycles the current grant has lasted, sticky error.
  int owner = 0;
  bit m_last_d = 1'b0;
  int gcyc = 0;
  bit m_err = 1'b0;
  bit e_iresp, e_dresp;

  task automatic model_step();
    bit ireq, dreq, e_stb, e_cyc, e_wr;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wd;
    ireq = i_action_stb && i_action_cyc;
    dreq = d_action_stb && d_action_cyc;
    e_stb = 0; e_cyc = 0; e_wr = 0; e_addr = '0; e_wd = '0;
    if (owner == 1) begin
      e_stb = i_action_stb; e_cyc = i_action_cyc; e_addr = i_address;
    end else if (owner == 2) begin
      e_stb = d_action_stb; e_cyc = d_action_cyc; e_addr = d_address;
      e_wr = d_write; e_wd = d_wdata;
    end
    e_iresp = (owner == 1) && l2_resp;
    e_dresp = (owner == 2) && l2_resp;
    chk("l2_stb", l2_action_stb, e_stb);
    chk("l2_cyc", l2_action_cyc, e_cyc);
    chk("l2_write", l2_write, e_wr);
    chk("l2_address", l2_address, e_addr);
    chk("l2_wdata", l2_wdata, e_wd);
    chk("i_resp", i_resp, e_iresp);
    chk("d_resp", d_resp, e_dresp);
    chk("i_retry", i_retry, ireq && !e_iresp);
    chk("d_retry", d_retry, dreq && !e_dresp);
    chk("i_rdata", i_rdata, l2_rdata);
    chk("d_rdata", d_rdata, l2_rdata);
    chk("timeout_err", timeout_err, m_err);
    // advance to the state seen after the coming clock edge
    if (!rst_n) begin
      owner = 0; m_last_d = 0; gcyc = 0; m_err = 0;
    end else if (owner == 0) begin
      if (ireq && dreq) owner = m_last_d ? 1 : 2;
      else if (ireq)    owner = 1;
      else if (dreq)    owner = 2;
      gcyc = 0;
    end else begin
      gcyc++;
      if (gcyc >= TO) m_err = 1;
      if (l2_resp) begin
        m_last_d = (owner == 2);
        owner = 0;
      end else if (!((owner == 1) ? i_action_cyc : d_action_cyc)) begin
        owner = 0;
      end
    end
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic fin();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic tick();
    neg(); fin();
  endtask

  task automatic set_i(bit r, logic [AW-1:0] a);
    i_action_stb = r; i_action_cyc = r; i_address = a;
  endtask

  task automatic set_d(bit r, bit w, logic [AW-1:0] a, logic [LW-1:0] wd);
    d_action_stb = r; d_action_cyc = r; d_write = w; d_address = a; d_wdata = wd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit ir, dr, rsp;
    bit e_stb;
    logic [AW-1:0] e_addr;
    bit e_wr, e_ir, e_dr, e_irt, e_drt;
  } vec_t;

  vec_t tbl[12];
  logic [LW-1:0] wpat, rpat;

  initial begin
    // table: tie after reset goes to D, then strict alternation, spurious resp in IDLE
    tbl[0]  = '{1, 1, 0, 0, 32'h0,    0, 0, 0, 1, 1};
    tbl[1]  = '{1, 1, 0, 1, 32'h2000, 1, 0, 0, 1, 1};
    tbl[2]  = '{1, 1, 1, 1, 32'h2000, 1, 0, 1, 1, 0};
    tbl[3]  = '{1, 1, 0, 0, 32'h0,    0, 0, 0, 1, 1};
    tbl[4]  = '{1, 1, 0, 1, 32'h1000, 0, 0, 0, 1, 1};
    tbl[5]  = '{1, 1, 1, 1, 32'h1000, 0, 1, 0, 0, 1};
    tbl[6]  = '{1, 1, 0, 0, 32'h0,    0, 0, 0, 1, 1};
    tbl[7]  = '{1, 1, 1, 1, 32'h2000, 1, 0, 1, 1, 0};
    tbl[8]  = '{1, 1, 0, 0, 32'h0,    0, 0, 0, 1, 1};
    tbl[9]  = '{1, 1, 1, 1, 32'h1000, 0, 1, 0, 0, 1};
    tbl[10] = '{0, 0, 1, 0, 32'h0,    0, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 32'h0,    0, 0, 0, 0, 0};
    wpat = {8{32'hA5C3_0F1E}};
    rpat = {8{32'h1234_5678}};

    rst_n = 1'b0;
    set_i(0, '0); set_d(0, 0, '0, '0);
    l2_resp = 0; l2_retry = 0; l2_rdata = rpat;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // table-driven sequence
    for (int k = 0; k < 12; k++) begin
      set_i(tbl[k].ir, 32'h1000);
      set_d(tbl[k].dr, 1'b1, 32'h2000, wpat);
      l2_resp = tbl[k].rsp;
      neg();
      chk($sformatf("tbl%0d_stb", k), l2_action_stb, tbl[k].e_stb);
      chk($sformatf("tbl%0d_addr", k), l2_address, tbl[k].e_addr);
      chk($sformatf("tbl%0d_write", k), l2_write, tbl[k].e_wr);
      chk($sformatf("tbl%0d_iresp", k), i_resp, tbl[k].e_ir);
      chk($sformatf("tbl%0d_dresp", k), d_resp, tbl[k].e_dr);
      chk($sformatf("tbl%0d_iretry", k), i_retry, tbl[k].e_irt);
      chk($sformatf("tbl%0d_dretry", k), d_retry, tbl[k].e_drt);
      if (tbl[k].e_wr) chk($sformatf("tbl%0d_wdata", k), l2_wdata, wpat);
      fin();
    end
    l2_resp = 0;

    // I-only request, L2 answers 3 cycles after forwarding
    do_reset();
    set_i(1, 32'h0000_1000);
    tick();
    neg();
    chk("i_only_addr", l2_address, 32'h1000);
    chk("i_only_write", l2_write, 1'b0);
    chk("i_only_retry", i_retry, 1'b1);
    fin();
    tick(); tick();
    l2_resp = 1; l2_rdata = {8{32'hCAFE_F00D}};
    neg();
    chk("i_only_resp", i_resp, 1'b1);
    chk("i_only_rdata", i_rdata, {8{32'hCAFE_F00D}});
    chk("i_only_dresp", d_resp, 1'b0);
    fin();
    l2_resp = 0; set_i(0, '0);
    tick();

    // D granted, aborts by dropping cyc; pending I is granted next
    do_reset();
    set_i(1, 32'h0000_3000);
    set_d(1, 1, 32'h0000_4000, wpat);
    tick(); tick();
    set_d(0, 1, 32'h0000_4000, wpat);
    neg();
    chk("abort_dresp", d_resp, 1'b0);
    fin();
    tick();
    neg();
    chk("abort_next_addr", l2_address, 32'h3000);
    chk("abort_next_stb", l2_action_stb, 1'b1);
    fin();
    l2_resp = 1; tick(); l2_resp = 0;
    set_i(0, '0);
    tick();

    // watchdog: L2 never responds
    do_reset();
    set_d(1, 0, 32'h0000_5000, '0);
    for (int c = 0; c < 9; c++) begin
      neg();
      if (c == 8) chk("wd_before", timeout_err, 1'b0);
      fin();
    end
    neg();
    chk("wd_set", timeout_err, 1'b1);
    fin();
    set_d(0, 0, '0, '0);
    repeat (4) tick();
    neg();
    chk("wd_sticky", timeout_err, 1'b1);
    fin();
    do_reset();
    neg();
    chk("wd_cleared", timeout_err, 1'b0);
    fin();

    // reset in the middle of a D grant
    set_d(1, 1, 32'h0000_6000, wpat);
    tick(); tick();
    rst_n = 0;
    tick();
    rst_n = 1; set_d(0, 0, '0, '0); l2_resp = 1;
    neg();
    chk("rst_mid_stb", l2_action_stb, 1'b0);
    chk("rst_mid_addr", l2_address, '0);
    chk("rst_mid_dresp", d_resp, 1'b0);
    fin();
    l2_resp = 0;
    tick();

    // randomized traffic from well-behaved requesters
    for (int c = 0; c < 3000; c++) begin
      l2_resp  = ($urandom_range(0, 2) == 0);
      l2_retry = $urandom_range(0, 1);
      for (int k = 0; k < 8; k++) l2_rdata[k*32 +: 32] = $urandom();
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
      if (i_action_cyc && i_action_stb) begin
        if (e_iresp || $urandom_range(0, 19) == 0)
          set_i($urandom_range(0, 1), AW'($urandom()));
      end else begin
        case ($urandom_range(0, 3))
          0, 1: set_i(1, AW'($urandom()));
          2: begin set_i(0, '0); i_action_stb = 1; end
          default: set_i(0, '0);
        endcase
      end
      if (d_action_cyc && d_action_stb) begin
        if (e_dresp || $urandom_range(0, 19) == 0)
          set_d($urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom()),
                {8{$urandom()}});
      end else begin
        case ($urandom_range(0, 3))
          0, 1: set_d(1, $urandom_range(0, 1), AW'($urandom()), {8{$urandom()}});
          2: begin set_d(0, 0, '0, '0); d_action_cyc = 1; end
          default: set_d(0, 0, '0, '0);
        endcase
      end
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
